// File: rtl/mem_stage_nport_if.sv
// mem_stage_nport_if: request/response/broadcast bundle for mem_stage_nport.
//   master : execute-side driver (interlock, living_sub_count, tag_in, req_*)
//            and consumer of tag_out, resp_*, sub_*.
//   slave  : the memory stage itself.
// Lane i of every packed vector occupies [i*W +: W] for that field's width W.
interface mem_stage_nport_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int TAG_W  = 138
);
  logic                      interlock;
  logic [3:0]                living_sub_count;
  logic [TAG_W-1:0]          tag_in;
  logic [LANES-1:0]          req_valid;
  logic [LANES-1:0]          req_we;
  logic [LANES*ADDR_W-1:0]   req_addr;
  logic [LANES*DATA_W-1:0]   req_din;

  logic [TAG_W-1:0]          tag_out;
  logic [LANES-1:0]          resp_valid;
  logic [LANES*DATA_W-1:0]   resp_dout;
  logic [LANES-1:0]          resp_oob;
  logic [LANES-1:0]          sub_we;
  logic [LANES*32-1:0]       sub_addr;
  logic [LANES*DATA_W-1:0]   sub_din;

  modport master (
    output interlock, living_sub_count, tag_in, req_valid, req_we, req_addr, req_din,
    input  tag_out, resp_valid, resp_dout, resp_oob, sub_we, sub_addr, sub_din
  );

  modport slave (
    input  interlock, living_sub_count, tag_in, req_valid, req_we, req_addr, req_din,
    output tag_out, resp_valid, resp_dout, resp_oob, sub_we, sub_addr, sub_din
  );
endinterface

// File: rtl/mem_stage_nport.sv
// mem_stage_nport: LANES-wide load/store stage against one shared
// word-addressed data memory, with pipeline sideband pass-through and a
// one-cycle store broadcast to the sub-cores.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : mem_stage_nport_if slave modport (requests in, responses and
//          store broadcast out)
// Pipeline: S1 captures the request bundle; the edge that moves S1 into S2
// commits stores, reads loads and registers the responses. interlock=1
// freezes both stages and the array.
module mem_stage_nport #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 32768,
  parameter int TAG_W  = 138
) (
  input logic              clk,
  input logic              rstn,
  mem_stage_nport_if.slave bus
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Data array, intentionally without reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // S1: captured request bundle.
  logic [LANES-1:0]             s1_valid_q, s1_valid_d;
  logic [LANES-1:0]             s1_we_q, s1_we_d;
  logic [LANES-1:0][ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [LANES-1:0][DATA_W-1:0] s1_din_q, s1_din_d;
  logic [TAG_W-1:0]             s1_tag_q, s1_tag_d;
  logic                         s1_bcast_q, s1_bcast_d;

  // S2: response and broadcast registers driving the outputs.
  logic [LANES-1:0]             resp_valid_q, resp_valid_d;
  logic [LANES-1:0]             resp_oob_q, resp_oob_d;
  logic [LANES-1:0][DATA_W-1:0] resp_dout_q, resp_dout_d;
  logic [TAG_W-1:0]             tag_out_q, tag_out_d;
  logic [LANES-1:0]             sub_we_q, sub_we_d;
  logic [LANES-1:0][31:0]       sub_addr_q, sub_addr_d;
  logic [LANES-1:0][DATA_W-1:0] sub_din_q, sub_din_d;

  logic                         advance_s;
  logic [LANES-1:0]             in_range_s;
  logic [LANES-1:0]             store_ok_s;
  logic [LANES-1:0][DATA_W-1:0] rd_data_s;

  // Per-lane qualification of the bundle sitting in S1.
  always_comb begin
    advance_s = ~bus.interlock;
    for (int i = 0; i < LANES; i++) begin
      in_range_s[i] = ({1'b0, s1_addr_q[i]} < DEPTH_EXT);
      store_ok_s[i] = s1_valid_q[i] & s1_we_q[i] & in_range_s[i];
    end
  end

  // Write-first load data: the array word, overridden by any in-range store
  // to the same address in this bundle; the loop order lets the highest
  // store lane win, matching the order of the array writes below.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (s1_valid_q[i] && in_range_s[i]) begin
        rd_data_s[i] = mem_q[s1_addr_q[i][IDX_W-1:0]];
        for (int j = 0; j < LANES; j++) begin
          if (store_ok_s[j] && (s1_addr_q[j] == s1_addr_q[i])) begin
            rd_data_s[i] = s1_din_q[j];
          end else begin
            rd_data_s[i] = rd_data_s[i];
          end
        end
      end else begin
        rd_data_s[i] = {DATA_W{1'b0}};
      end
    end
  end

  // Next-state for S1 and S2; everything holds under interlock except the
  // broadcast strobe, which is a single-cycle pulse.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_we_d      = s1_we_q;
    s1_addr_d    = s1_addr_q;
    s1_din_d     = s1_din_q;
    s1_tag_d     = s1_tag_q;
    s1_bcast_d   = s1_bcast_q;
    resp_valid_d = resp_valid_q;
    resp_oob_d   = resp_oob_q;
    resp_dout_d  = resp_dout_q;
    tag_out_d    = tag_out_q;
    sub_we_d     = {LANES{1'b0}};
    sub_addr_d   = sub_addr_q;
    sub_din_d    = sub_din_q;
    if (advance_s) begin
      s1_valid_d = bus.req_valid;
      s1_we_d    = bus.req_we;
      s1_addr_d  = bus.req_addr;
      s1_din_d   = bus.req_din;
      s1_tag_d   = bus.tag_in;
      s1_bcast_d = (bus.living_sub_count == 4'd0);
      tag_out_d  = s1_tag_q;
      for (int i = 0; i < LANES; i++) begin
        resp_valid_d[i] = s1_valid_q[i];
        resp_oob_d[i]   = s1_valid_q[i] & ~in_range_s[i];
        if (!s1_valid_q[i]) begin
          resp_dout_d[i] = {DATA_W{1'b0}};
        end else if (s1_we_q[i]) begin
          resp_dout_d[i] = s1_din_q[i];
        end else begin
          resp_dout_d[i] = rd_data_s[i];
        end
        sub_we_d[i] = store_ok_s[i] & s1_bcast_q;
        if (sub_we_d[i]) begin
          sub_addr_d[i] = 32'({s1_addr_q[i], 2'b00});
          sub_din_d[i]  = s1_din_q[i];
        end else begin
          sub_addr_d[i] = sub_addr_q[i];
          sub_din_d[i]  = sub_din_q[i];
        end
      end
    end else begin
      sub_we_d = {LANES{1'b0}};
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q   <= {LANES{1'b0}};
      s1_we_q      <= {LANES{1'b0}};
      s1_addr_q    <= {(LANES*ADDR_W){1'b0}};
      s1_din_q     <= {(LANES*DATA_W){1'b0}};
      s1_tag_q     <= {TAG_W{1'b0}};
      s1_bcast_q   <= 1'b0;
      resp_valid_q <= {LANES{1'b0}};
      resp_oob_q   <= {LANES{1'b0}};
      resp_dout_q  <= {(LANES*DATA_W){1'b0}};
      tag_out_q    <= {TAG_W{1'b0}};
      sub_we_q     <= {LANES{1'b0}};
      sub_addr_q   <= {(LANES*32){1'b0}};
      sub_din_q    <= {(LANES*DATA_W){1'b0}};
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_we_q      <= s1_we_d;
      s1_addr_q    <= s1_addr_d;
      s1_din_q     <= s1_din_d;
      s1_tag_q     <= s1_tag_d;
      s1_bcast_q   <= s1_bcast_d;
      resp_valid_q <= resp_valid_d;
      resp_oob_q   <= resp_oob_d;
      resp_dout_q  <= resp_dout_d;
      tag_out_q    <= tag_out_d;
      sub_we_q     <= sub_we_d;
      sub_addr_q   <= sub_addr_d;
      sub_din_q    <= sub_din_d;
    end
  end

  // Array commit; ascending lane order makes the highest lane's write land last.
  always_ff @(posedge clk) begin
    if (advance_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (store_ok_s[i]) begin
          mem_q[s1_addr_q[i][IDX_W-1:0]] <= s1_din_q[i];
        end
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_oob   = resp_oob_q;
  assign bus.resp_dout  = resp_dout_q;
  assign bus.tag_out    = tag_out_q;
  assign bus.sub_we     = sub_we_q;
  assign bus.sub_addr   = sub_addr_q;
  assign bus.sub_din    = sub_din_q;

endmodule

// File: doc/mem_stage_nport.md
# mem_stage_nport

Parametrised data-memory stage for the 2nd-generation core: services `LANES` independent load/store requests per cycle against one shared word-addressed data memory. It carries the pipeline sideband (pc/inst/fetch_core/rt, packed as a tag) alongside the data. It also broadcasts committed stores to the sub-cores. It sits between the execute stage and write-back. Everything runs on the rising edge; no negedge logic.

## Interface
- `LANES`, 2: number of request lanes (1..4).
- `DATA_W`, 32: data word width.
- `ADDR_W`, 17: word-address width per lane.
- `DEPTH`, 32768: implemented words; addresses >= `DEPTH` are out of range.
- `TAG_W`, 138: sideband width passed through unchanged.
- `clk` in 1: clock. One clock; every register uses `posedge clk`.
- `rstn` in 1: reset. Asynchronous, active-low.
- `interlock` in 1: when high, the whole stage holds.
- `living_sub_count` in 4: live sub-core count; store broadcast is enabled only when it is 0.
- `tag_in` in `TAG_W`: sideband of the incoming bundle.
- `req_valid` in `LANES`: per-lane request valid.
- `req_we` in `LANES`: per-lane store (1) or load (0).
- `req_addr` in `LANES*ADDR_W`: word addresses; lane i occupies `[i*ADDR_W +: ADDR_W]`.
- `req_din` in `LANES*DATA_W`: store data, packed the same way.
- `tag_out` out `TAG_W`: sideband aligned with `resp_*`.
- `resp_valid` out `LANES`: response valid per lane.
- `resp_dout` out `LANES*DATA_W`: load data; stores return the written value.
- `resp_oob` out `LANES`: request address was out of range.
- `sub_we` out `LANES`: one-cycle store broadcast pulse.
- `sub_addr` out `LANES*32`: byte address, `{zeros, addr, 2'b00}`.
- `sub_din` out `LANES*DATA_W`: broadcast store data.

## Operation
- Two register stages:
  - S1 (request capture).
  - S2 (array access plus response register).
- Advance edge: a rising edge with `interlock`=0.
  - On an advance edge, S1 <= inputs, and S2 <= result of S1.
  - With `interlock`=1, S1, S2, `tag_out`, `resp_*` and the array all hold. No write commits.
- Commit: on the advance edge that moves S1 into S2, each valid S1 store lane with an in-range address writes the array.
- Loads read the array on the same edge.
- Out of range (`addr >= DEPTH`):
  - Stores are suppressed and not broadcast.
  - Loads return 0.
  - `resp_oob`=1 for that lane.
- Write conflict: when several lanes in one bundle store to the same address, the highest lane index wins.
- Read-during-write is write-first. A load in the same bundle as a store to its address returns the value that ends up stored (the highest store lane's data). A store lane's `resp_dout` is its own `din`.
- Loads in a later bundle see all earlier commits. There is no stale data across bundles.
- Invalid lanes:
  - No array access and no broadcast.
  - `resp_valid`=0; `resp_dout` and `resp_oob` are 0.
- Broadcast timing:
  - `sub_we[i]` is registered on the commit edge. It is 1 iff the lane is a valid, in-range store and `living_sub_count` was 0 when the bundle entered S1.
  - It clears on the next rising edge unconditionally, even if `interlock` rises, so one commit gives exactly one pulse.
- `sub_addr` and `sub_din` update on the commit edge and hold otherwise.
- `tag_out` is the `tag_in` captured with the bundle, so it stays aligned with `resp_*`.
- Array contents are not reset and are undefined after power-up.

## Timing
- Latency: a bundle sampled at advance edge N appears on `resp_*`/`tag_out` after advance edge N+1. With no interlock that is 2 edges.
- Throughput: one bundle per cycle with no bubbles.
- Broadcast: `sub_we` is high during the same cycle the matching `resp_valid` is first presented.
- Reset values, applied asynchronously while `rstn`=0:
  - `resp_valid`, `resp_oob`, `sub_we` = 0.
  - `resp_dout`, `sub_addr`, `sub_din`, `tag_out` = 0.
  - S1 valid bits cleared.
- Reset mid-operation drops in-flight bundles. A store still in S1 never commits. A store already committed stays in the array.
- Release from reset is synchronised by the surrounding core. The first advance edge after release samples inputs normally.
- `living_sub_count` is sampled only at S1 capture. Changes while the bundle is held under interlock have no effect on it.

## Test plan
- Store then load, `LANES`=2:
  - Lane0 stores 0xDEADBEEF to addr 5 at edge 0, and lane1 loads addr 5 at edge 1.
  - Required: the lane1 `resp_dout`=0xDEADBEEF after edge 2, and `sub_we[0]` pulses for exactly one cycle after edge 1.
- Same-bundle conflict:
  - Lane0 stores 0x1111 and lane1 stores 0x2222 to addr 9, then the next bundle loads addr 9.
  - Required: it returns 0x2222.
- Write-first:
  - Lane1 stores 0xA5A5 to addr 3 while lane0 loads addr 3 in the same bundle.
  - Required: the lane0 `resp_dout`=0xA5A5.
- Out of range:
  - Store and then load at addr `DEPTH`.
  - Required: `resp_oob`=1, load data 0, `sub_we`=0, and addr 0 unchanged.
- Interlock:
  - Assert `interlock` for 3 cycles with a store in S1.
  - Required: outputs hold, there is no commit, and `sub_we` stays 0. The commit and a single pulse occur on the first edge after release.
  - Separately, with `living_sub_count`=2 at capture, a store commits but `sub_we` stays 0.
- Async reset:
  - Drop `rstn` mid-cycle with stores in S1 and S2.
  - Required: all outputs read 0 immediately. The S1 store is absent on a later load of its address, and the S2 store is present.
